braille_writer: RTL and testbench

BRAILLE_WRITER -- requirements
Module: braille_writer

---
 rtl/braille_pkg.sv | 16 +
 rtl/braille_writer_btn_edge.sv | 30 +++
 rtl/braille_writer.sv | 149 ++++++++++++++
 tb/tb_braille_writer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/braille_pkg.sv
// Shared definitions for the braille writer: FSM encoding and the fixed
// byte values seen on the reader link.
package braille_pkg;

    typedef enum logic [1:0] {
        EDIT   = 2'd0,
        HEADER = 2'd1,
        STREAM = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic [7:0] HEADER_BYTE = 8'h00;
    localparam logic [7:0] START_CODE  = 8'h17;
    localparam logic [7:0] END_CODE    = 8'h01;

endpackage

// File: rtl/braille_writer_btn_edge.sv
// Two-flop synchronizer for a raw push button with a falling-edge detector;
// fall is high for one cycle, two cycles after the raw input drops.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic fall
);

    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        sync_d = btn;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/braille_writer.sv
// Braille cell writer: collects dot patterns from button presses into a buffer
// and streams them as a header-plus-data transfer with fully registered outputs.
module braille_writer
    import braille_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dots,
    input  logic       enter,
    input  logic       erase,
    input  logic       send,
    output logic [7:0] braille_out,
    output logic [7:0] braille_size,
    output logic       braille_valid,
    output logic [7:0] count,
    output logic       busy,
    output logic       overflow
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DEPTH_C = 8'(DEPTH);

    logic enter_fall, erase_fall, send_fall;

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] rd_q, rd_d;
    logic [7:0] out_q, out_d;
    logic [7:0] size_q, size_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       overflow_q, overflow_d;

    logic       wr_en;
    logic [7:0] rd_data;
    logic [7:0] buf_mem [DEPTH];

    btn_edge u_enter (.clk(clk), .reset(reset), .btn(enter), .fall(enter_fall));
    btn_edge u_erase (.clk(clk), .reset(reset), .btn(erase), .fall(erase_fall));
    btn_edge u_send  (.clk(clk), .reset(reset), .btn(send),  .fall(send_fall));

    // Buffer contents survive reset; count=0 makes stale cells unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[count_q[AW-1:0]] <= dots;
        end
    end

    assign rd_data = buf_mem[rd_q[AW-1:0]];

    // Outputs are computed for the state being entered so they appear
    // registered in the same cycle the FSM is in that state.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_d       = rd_q;
        out_d      = HEADER_BYTE;
        size_d     = 8'h00;
        valid_d    = 1'b0;
        busy_d     = 1'b0;
        overflow_d = 1'b0;
        wr_en      = 1'b0;

        case (state_q)
            EDIT: begin
                if (send_fall && count_q != 8'h00) begin
                    state_d = HEADER;
                    rd_d    = 8'h00;
                    valid_d = 1'b1;
                    size_d  = count_q;
                    busy_d  = 1'b1;
                end else if (enter_fall && !erase_fall) begin
                    if (count_q < DEPTH_C) begin
                        wr_en   = 1'b1;
                        count_d = count_q + 8'd1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (erase_fall && !enter_fall && count_q != 8'h00) begin
                    count_d = count_q - 8'd1;
                end
            end

            HEADER: begin
                state_d = STREAM;
                valid_d = 1'b1;
                size_d  = size_q;
                busy_d  = 1'b1;
                out_d   = rd_data;
                rd_d    = rd_q + 8'd1;
            end

            // rd points at the next cell to load; reaching count ends the data.
            STREAM: begin
                busy_d = 1'b1;
                if (rd_q == count_q) begin
                    state_d = GAP;
                end else begin
                    valid_d = 1'b1;
                    size_d  = size_q;
                    out_d   = rd_data;
                    rd_d    = rd_q + 8'd1;
                end
            end

            GAP: begin
                state_d = EDIT;
                count_d = 8'h00;
                rd_d    = 8'h00;
            end

            default: begin
                state_d = EDIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EDIT;
            count_q    <= 8'h00;
            rd_q       <= 8'h00;
            out_q      <= 8'h00;
            size_q     <= 8'h00;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            out_q      <= out_d;
            size_q     <= size_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign braille_out   = out_q;
    assign braille_size  = size_q;
    assign braille_valid = valid_q;
    assign count         = count_q;
    assign busy          = busy_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_braille_writer.sv
// Drives two writers (DEPTH 32 and 4) with shared stimulus and checks every
// cycle against a frame-level model built from buffer arrays and positions.
module tb_braille_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] dots = 8'h00;
    logic       enter = 1'b1;
    logic       erase = 1'b1;
    logic       send = 1'b1;

    logic [7:0] o_out   [2];
    logic [7:0] o_size  [2];
    logic       o_valid [2];
    logic [7:0] o_count [2];
    logic       o_busy  [2];
    logic       o_ovf   [2];

    int pass_cnt = 0;
    int total_cnt = 0;

    // Model: buffered cells per instance, and position within a transfer
    // (0 = editing, 1 = header, 2..n+1 = data, n+2 = gap).
    logic [7:0] mbuf [2][256];
    int         mn   [2];
    int         mx   [2];
    logic       movf [2];
    int         mdep [2] = '{32, 4};
    logic [2:0] h1, h2;

    logic [7:0] cap0[$];
    logic [7:0] cap1[$];
    int         ovf_seen1;

    braille_writer #(.DEPTH(32)) dut32 (
        .clk(clk), .reset(reset), .dots(dots), .enter(enter), .erase(erase), .send(send),
        .braille_out(o_out[0]), .braille_size(o_size[0]), .braille_valid(o_valid[0]),
        .count(o_count[0]), .busy(o_busy[0]), .overflow(o_ovf[0])
    );

    braille_writer #(.DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .dots(dots), .enter(enter), .erase(erase), .send(send),
        .braille_out(o_out[1]), .braille_size(o_size[1]), .braille_valid(o_valid[1]),
        .count(o_count[1]), .busy(o_busy[1]), .overflow(o_ovf[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] check %s failed", tag);
        end
    endtask

    task automatic model_reset();
        h1 = 3'b000;
        h2 = 3'b000;
        for (int i = 0; i < 2; i++) begin
            mn[i] = 0;
            mx[i] = 0;
            movf[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [2:0] fl;
        fl = h2 & ~h1;
        h2 = h1;
        h1 = {send, erase, enter};
        for (int i = 0; i < 2; i++) begin
            movf[i] = 1'b0;
            if (mx[i] != 0) begin
                mx[i]++;
                if (mx[i] > mn[i] + 2) begin
                    mx[i] = 0;
                    mn[i] = 0;
                end
            end else if (fl[2] && mn[i] > 0) begin
                mx[i] = 1;
            end else if (fl[0] && fl[1]) begin
                mx[i] = 0;
            end else if (fl[0]) begin
                if (mn[i] < mdep[i]) begin
                    mbuf[i][mn[i]] = dots;
                    mn[i]++;
                end else begin
                    movf[i] = 1'b1;
                end
            end else if (fl[1] && mn[i] > 0) begin
                mn[i]--;
            end
        end
    endtask

    task automatic checkOutput();
        logic       ev;
        logic [7:0] eo;
        for (int i = 0; i < 2; i++) begin
            ev = (mx[i] >= 1) && (mx[i] <= mn[i] + 1);
            eo = (ev && mx[i] >= 2) ? mbuf[i][mx[i] - 2] : 8'h00;
            check($sformatf("valid[%0d]", i), 32'(o_valid[i]), 32'(ev));
            check($sformatf("out[%0d]", i), 32'(o_out[i]), 32'(eo));
            check($sformatf("size[%0d]", i), 32'(o_size[i]), ev ? mn[i] : 0);
            check($sformatf("busy[%0d]", i), 32'(o_busy[i]), 32'(mx[i] != 0));
            check($sformatf("count[%0d]", i), 32'(o_count[i]), mn[i]);
            check($sformatf("overflow[%0d]", i), 32'(o_ovf[i]), 32'(movf[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else model_step();
        #1;
        checkOutput();
        if (o_valid[0]) cap0.push_back(o_out[0]);
        if (o_valid[1]) cap1.push_back(o_out[1]);
        if (o_ovf[1]) ovf_seen1++;
    endtask

    // mask bit 0 = enter, bit 1 = erase, bit 2 = send
    task automatic applyStimulus(input logic [2:0] mask, input logic [7:0] d, input int hold);
        dots = d;
        if (mask[0]) enter = 1'b0;
        if (mask[1]) erase = 1'b0;
        if (mask[2]) send = 1'b0;
        repeat (hold) tick();
        enter = 1'b1;
        erase = 1'b1;
        send = 1'b1;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int guard;

        repeat (2) tick();
        reset = 1'b1;
        tick();

        // three cells then send
        applyStimulus(3'b001, 8'h01, 1);
        check("count_after_1", 32'(o_count[0]), 1);
        applyStimulus(3'b001, 8'h03, 2);
        check("count_after_2", 32'(o_count[0]), 2);
        applyStimulus(3'b001, 8'h09, 1);
        check("count_after_3", 32'(o_count[0]), 3);
        cap0.delete();
        applyStimulus(3'b100, 8'h00, 1);
        repeat (8) tick();
        check("s1_len", cap0.size(), 4);
        if (cap0.size() == 4) begin
            check("s1_hdr", 32'(cap0[0]), 32'h00);
            check("s1_d0", 32'(cap0[1]), 32'h01);
            check("s1_d1", 32'(cap0[2]), 32'h03);
            check("s1_d2", 32'(cap0[3]), 32'h09);
        end
        check("s1_count_cleared", 32'(o_count[0]), 0);

        // overflow on the depth-4 instance
        do_reset();
        for (int k = 0; k < 4; k++) applyStimulus(3'b001, 8'h40 + 8'(k), 1);
        ovf_seen1 = 0;
        applyStimulus(3'b001, 8'hEE, 3);
        check("s2_ovf_pulses", ovf_seen1, 1);
        check("s2_count4", 32'(o_count[1]), 4);
        cap1.delete();
        applyStimulus(3'b100, 8'h00, 1);
        repeat (10) tick();
        check("s2_len", cap1.size(), 5);
        if (cap1.size() == 5) begin
            for (int k = 0; k < 4; k++) check($sformatf("s2_d%0d", k), 32'(cap1[k + 1]), 32'h40 + k);
        end

        // erase behaviour
        do_reset();
        applyStimulus(3'b010, 8'h00, 1);
        check("s3_erase_empty", 32'(o_count[0]), 0);
        applyStimulus(3'b001, 8'h07, 1);
        applyStimulus(3'b001, 8'h0F, 1);
        applyStimulus(3'b010, 8'h00, 1);
        applyStimulus(3'b001, 8'h1B, 1);
        cap0.delete();
        applyStimulus(3'b100, 8'h00, 1);
        repeat (8) tick();
        check("s3_len", cap0.size(), 3);
        if (cap0.size() == 3) begin
            check("s3_d0", 32'(cap0[1]), 32'h07);
            check("s3_d1", 32'(cap0[2]), 32'h1B);
        end

        // send on empty, simultaneous enter and erase
        cap0.delete();
        applyStimulus(3'b100, 8'h00, 1);
        check("s4_no_xfer", cap0.size(), 0);
        applyStimulus(3'b001, 8'h22, 1);
        applyStimulus(3'b011, 8'h33, 1);
        check("s4_count_kept", 32'(o_count[0]), 1);
        check("s4_no_valid", cap0.size(), 0);

        // reset during the second data cycle of a 5-cell transfer
        do_reset();
        for (int k = 0; k < 5; k++) applyStimulus(3'b001, 8'h50 + 8'(k), 1);
        send = 1'b0;
        tick();
        send = 1'b1;
        guard = 0;
        while (mx[0] != 3 && guard < 40) begin
            tick();
            guard++;
        end
        check("s5_in_stream", 32'(o_valid[0]), 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("s5_valid_drop", 32'(o_valid[0]), 0);
        check("s5_count_zero", 32'(o_count[0]), 0);
        check("s5_busy_zero", 32'(o_busy[0]), 0);
        tick();
        reset = 1'b1;
        tick();
        applyStimulus(3'b001, 8'h61, 1);
        applyStimulus(3'b001, 8'h62, 1);
        cap0.delete();
        applyStimulus(3'b100, 8'h00, 1);
        repeat (8) tick();
        check("s5_refill_len", cap0.size(), 3);
        if (cap0.size() == 3) begin
            check("s5_refill_d0", 32'(cap0[1]), 32'h61);
            check("s5_refill_d1", 32'(cap0[2]), 32'h62);
        end

        // randomized button activity, including presses while busy
        for (int c = 0; c < 800; c++) begin
            dots  = 8'($urandom);
            enter = ($urandom_range(0, 2) != 0);
            erase = ($urandom_range(0, 7) != 0);
            send  = ($urandom_range(0, 24) != 0);
            tick();
        end
        enter = 1'b1;
        erase = 1'b1;
        send = 1'b1;
        repeat (10) tick();

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
